conv_top_mc: RTL and testbench
==============================

Name: conv_top_mc

Overview:
- Multi-output-channel convolution top. Next generation of the single-output conv top.
- Runs InputDim input channels against OutputDim independent kernels in parallel. Instantiates one LineBuffer per input channel and one ConvChannel per output channel.
- Adds a control FSM with start/done, weight and data handshakes, and error flagging.
- Restarts with a start pulse only; no external reset is needed between layers.

Parameters:
- DataWidth, 64, width of one sample/weight/result.
- KernelSize, 9, taps per kernel per input channel (KernelSide*KernelSide).
- KernelSide, 3, kernel edge length.
- InputDim, 4, input channels.
- OutputDim, 2, output channels (parallel ConvChannel instances).
- MaxRowWidth, 9, bits of row size (max 416).
- MaxColWidth, 9, bits of column size (max 416).

Ports:
- Clk  in  1  clock.
- Rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a layer; ignored while busy.
- row_in  in  MaxRowWidth  image rows, sampled on start.
- col_in  in  MaxColWidth  image columns, sampled on start.
- weight_in  in  InputDim*DataWidth  one tap for all input channels; channel 0 in the LSBs.
- weight_valid  in  1  weight beat valid.
- weight_ready  out  1  high only in LOAD_W.
- data_in  in  InputDim*DataWidth  one pixel for all input channels; channel 0 in the LSBs.
- data_valid  in  1  pixel valid.
- data_ready  out  1  high in RUN until all pixels are accepted.
- result_out  out  OutputDim*DataWidth  output channel k at bits [k*DataWidth +: DataWidth].
- result_valid  out  1  result_out valid.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse at layer end.
- err  out  1  sticky error; cleared by the next accepted start.

Behaviour:
- Reset (Rst_n low, asynchronous): state IDLE; all counters 0; all outputs 0.
- Internal sub_rst (active-high, synchronous) drives the Rst input of every LineBuffer and ConvChannel. It is high during CLEAR.
- Layer size registers row_q and col_q are loaded on start in IDLE. Derived values:
  - P = row_q*col_q (pixels in).
  - R = (row_q-KernelSide+1)*(col_q-KernelSide+1) (results out).
- Counter widths: pix_cnt and res_cnt are MaxRowWidth+MaxColWidth bits; w_cnt is ceil(log2(KernelSize)) bits; oc_cnt is ceil(log2(OutputDim)) bits.
- FSM states: IDLE, CLEAR, LOAD_W, RUN, DONE.
- IDLE:
  - On start, clear err and latch sizes.
  - If row_in<KernelSide, col_in<KernelSide, row_in>416 or col_in>416: set err and stay in IDLE.
  - Otherwise go to CLEAR.
- CLEAR: exactly 2 cycles with sub_rst=1, then LOAD_W.
- LOAD_W:
  - weight_ready=1. A beat is accepted when weight_valid&weight_ready; gaps are allowed.
  - The accepted beat drives weight_valid of ConvChannel[oc_cnt] only.
  - w_cnt increments per beat and wraps at KernelSize-1, then oc_cnt increments.
  - After OutputDim*KernelSize beats, go to RUN on the next cycle.
- RUN:
  - data_ready=1 while pix_cnt<P.
  - The first accepted pixel starts a streaming phase. data_valid must then stay high for P consecutive cycles.
  - A deassert mid-stream sets err. The affected pixels are not counted, and the stream is not resumed.
  - The accepted pixel strobe (data_valid&data_ready) feeds every LineBuffer data_valid; data_in lanes are split per channel.
  - Each LineBuffer window bus is broadcast to all ConvChannels. Their window_valid is the AND of all LineBuffer ready flags.
  - result_valid = AND of all ConvChannel result_ready. result_out is the concatenation of their results, registered 0 extra cycles (direct).
  - If any but not all channels assert result_ready in a cycle, set err.
  - res_cnt increments per result_valid. When res_cnt reaches R, go to DONE. data_ready is already 0 by then.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Out-of-state traffic: weight_valid outside LOAD_W and data_valid outside RUN are ignored (no count, no forward).
- start while busy: ignored, no effect.
- Reset mid-operation: immediate return to IDLE. Submodules are cleared by the next CLEAR.

Test Plan:
- Nominal 5x5 layer: reset, start with row=5 col=5, 18 weight beats with 3 idle gaps, 25 continuous pixels -> exactly 9 result_valid cycles, done one cycle after the 9th, busy falls with done. With all weights=1 and all pixels=1, each output lane = 36 (9 taps x 4 channels).
- Per-channel routing: kernel0 weights=1, kernel1 weights=2, pixels=1 -> lane0=36, lane1=72 on every result.
- Bad size: start with row=2 col=5 -> err=1, busy stays 0, weight_ready stays 0. A subsequent valid start clears err.
- Stream break: data_valid drops at pixel 10 of 25 -> err=1. pix_cnt holds at 10.
- Back-to-back layers without reset: run 5x5 then 4x6 -> 9 then 8 results; second layer's results are unaffected by the first.
- Async reset mid-RUN: Rst_n low for 1 cycle after pixel 12 -> all outputs 0 immediately; a new start then completes a 5x5 layer with 9 results.

Source files
------------

// File: rtl/conv_top_mc.sv
// Multi-output-channel 3x3 convolution: one line buffer per input channel feeds
// OutputDim parallel kernels, sequenced by a start/done control FSM.

module LineBuffer #(
  parameter int DataWidth   = 64,
  parameter int KernelSide  = 3,
  parameter int KernelSize  = 9,
  parameter int MaxRowWidth = 9,
  parameter int MaxColWidth = 9,
  parameter int MaxCols     = 416
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic [MaxColWidth-1:0]           i_col,
  input  logic                             i_valid,
  input  logic [DataWidth-1:0]             i_data,
  output logic [KernelSize*DataWidth-1:0]  o_window,
  output logic                             o_ready
);
  localparam int Depth = (KernelSide-1)*MaxCols + KernelSide;
  localparam int IdxW  = $clog2(Depth);
  localparam logic [MaxRowWidth-1:0] RowFirst = MaxRowWidth'(KernelSide-1);
  localparam logic [MaxColWidth-1:0] ColFirst = MaxColWidth'(KernelSide-1);

  logic [DataWidth-1:0]   r_sr [Depth];
  logic [MaxColWidth-1:0] r_colIdx;
  logic [MaxRowWidth-1:0] r_rowIdx;
  logic                   r_ready;

  // A window is complete once the newest pixel sits at least two rows and two columns in.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_colIdx <= '0;
      r_rowIdx <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (i_valid) begin
        r_ready <= (r_rowIdx >= RowFirst) && (r_colIdx >= ColFirst);
        if (r_colIdx == i_col - 1'b1) begin
          r_colIdx <= '0;
          r_rowIdx <= r_rowIdx + 1'b1;
        end else begin
          r_colIdx <= r_colIdx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (i_valid) begin
      r_sr[0] <= i_data;
      for (int i = 1; i < Depth; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  // Tap (ky,kx) lies (2-ky) rows and (2-kx) samples behind the newest pixel.
  for (genvar ky = 0; ky < KernelSide; ky++) begin : g_row
    for (genvar kx = 0; kx < KernelSide; kx++) begin : g_col
      logic [IdxW-1:0] w_idx;
      assign w_idx = IdxW'((KernelSide-1-ky)*int'(i_col) + (KernelSide-1-kx));
      assign o_window[(ky*KernelSide+kx)*DataWidth +: DataWidth] = r_sr[w_idx];
    end
  end

  assign o_ready = r_ready;
endmodule

module ConvChannel #(
  parameter int DataWidth  = 64,
  parameter int KernelSize = 9,
  parameter int InputDim   = 4
) (
  input  logic                                    Clk,
  input  logic                                    Rst,
  input  logic                                    i_weightValid,
  input  logic [InputDim*DataWidth-1:0]           i_weight,
  input  logic                                    i_windowValid,
  input  logic [InputDim*KernelSize*DataWidth-1:0] i_window,
  output logic [DataWidth-1:0]                    o_result,
  output logic                                    o_resultReady
);
  logic [InputDim*DataWidth-1:0] r_weights [KernelSize];
  logic [DataWidth-1:0]          r_result;
  logic [DataWidth-1:0]          w_sum;
  logic                          r_ready;

  always_comb begin
    w_sum = '0;
    for (int ic = 0; ic < InputDim; ic++)
      for (int t = 0; t < KernelSize; t++)
        w_sum = w_sum + i_window[(ic*KernelSize+t)*DataWidth +: DataWidth]
                      * r_weights[t][ic*DataWidth +: DataWidth];
  end

  // Weights shift toward index 0 so the first beat loaded ends up as tap 0.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int t = 0; t < KernelSize; t++) r_weights[t] <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (i_weightValid) begin
        for (int t = 0; t < KernelSize-1; t++) r_weights[t] <= r_weights[t+1];
        r_weights[KernelSize-1] <= i_weight;
      end
      r_ready <= i_windowValid;
      if (i_windowValid) r_result <= w_sum;
    end
  end

  assign o_result      = r_result;
  assign o_resultReady = r_ready;
endmodule

module conv_top_mc #(
  parameter int DataWidth   = 64,
  parameter int KernelSize  = 9,
  parameter int KernelSide  = 3,
  parameter int InputDim    = 4,
  parameter int OutputDim   = 2,
  parameter int MaxRowWidth = 9,
  parameter int MaxColWidth = 9
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic                           start,
  input  logic [MaxRowWidth-1:0]         row_in,
  input  logic [MaxColWidth-1:0]         col_in,
  input  logic [InputDim*DataWidth-1:0]  weight_in,
  input  logic                           weight_valid,
  output logic                           weight_ready,
  input  logic [InputDim*DataWidth-1:0]  data_in,
  input  logic                           data_valid,
  output logic                           data_ready,
  output logic [OutputDim*DataWidth-1:0] result_out,
  output logic                           result_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);
  localparam logic [2:0] StIdle = 3'd0, StClear = 3'd1, StLoadW = 3'd2, StRun = 3'd3, StDone = 3'd4;
  localparam int CntW  = MaxRowWidth + MaxColWidth;
  localparam int WCntW = $clog2(KernelSize);
  localparam int OcW   = (OutputDim > 1) ? $clog2(OutputDim) : 1;
  localparam logic [WCntW-1:0]       WLast  = WCntW'(KernelSize-1);
  localparam logic [OcW-1:0]         OcLast = OcW'(OutputDim-1);
  localparam logic [MaxRowWidth-1:0] RowMin = MaxRowWidth'(KernelSide);
  localparam logic [MaxRowWidth-1:0] RowMax = MaxRowWidth'(416);
  localparam logic [MaxColWidth-1:0] ColMin = MaxColWidth'(KernelSide);
  localparam logic [MaxColWidth-1:0] ColMax = MaxColWidth'(416);
  localparam logic [CntW-1:0]        Shrink = CntW'(KernelSide-1);

  logic [2:0]             r_state;
  logic                   r_clrCnt;
  logic [MaxRowWidth-1:0] r_rowQ;
  logic [MaxColWidth-1:0] r_colQ;
  logic [CntW-1:0]        r_pixCnt, r_resCnt;
  logic [WCntW-1:0]       r_wCnt;
  logic [OcW-1:0]         r_ocCnt;
  logic                   r_streaming, r_broken, r_err;

  logic [CntW-1:0]  w_pixTotal, w_resTotal;
  logic             w_subRst, w_wAcc, w_pixAcc, w_badSize, w_winValid, w_allRdy, w_anyRdy;
  logic [InputDim-1:0]  w_lbReady;
  logic [OutputDim-1:0] w_ccReady;
  logic [InputDim*KernelSize*DataWidth-1:0] w_window;
  logic [OutputDim*DataWidth-1:0]           w_results;

  assign w_pixTotal = CntW'(r_rowQ) * CntW'(r_colQ);
  assign w_resTotal = (CntW'(r_rowQ) - Shrink) * (CntW'(r_colQ) - Shrink);
  assign w_badSize  = (row_in < RowMin) || (col_in < ColMin) || (row_in > RowMax) || (col_in > ColMax);
  assign w_subRst   = (r_state == StClear);
  assign w_wAcc     = weight_valid && weight_ready;
  assign w_pixAcc   = data_valid && data_ready;
  assign w_winValid = &w_lbReady;
  assign w_allRdy   = &w_ccReady;
  assign w_anyRdy   = |w_ccReady;

  assign weight_ready = (r_state == StLoadW);
  assign data_ready   = (r_state == StRun) && (r_pixCnt < w_pixTotal) && !r_broken;
  assign result_valid = (r_state == StRun) && w_allRdy;
  assign result_out   = result_valid ? w_results : '0;
  assign busy         = (r_state == StClear) || (r_state == StLoadW) || (r_state == StRun);
  assign done         = (r_state == StDone);
  assign err          = r_err;

  // Once streaming has begun, any cycle without a pixel while more are owed breaks the layer for good.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= StIdle;
      r_clrCnt    <= 1'b0;
      r_rowQ      <= '0;
      r_colQ      <= '0;
      r_pixCnt    <= '0;
      r_resCnt    <= '0;
      r_wCnt      <= '0;
      r_ocCnt     <= '0;
      r_streaming <= 1'b0;
      r_broken    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: if (start) begin
          r_err       <= w_badSize;
          r_rowQ      <= row_in;
          r_colQ      <= col_in;
          r_pixCnt    <= '0;
          r_resCnt    <= '0;
          r_wCnt      <= '0;
          r_ocCnt     <= '0;
          r_clrCnt    <= 1'b0;
          r_streaming <= 1'b0;
          r_broken    <= 1'b0;
          if (!w_badSize) r_state <= StClear;
        end
        StClear: begin
          r_clrCnt <= 1'b1;
          if (r_clrCnt) r_state <= StLoadW;
        end
        StLoadW: if (w_wAcc) begin
          if (r_wCnt == WLast) begin
            r_wCnt  <= '0;
            r_ocCnt <= r_ocCnt + 1'b1;
            if (r_ocCnt == OcLast) begin
              r_ocCnt <= '0;
              r_state <= StRun;
            end
          end else begin
            r_wCnt <= r_wCnt + 1'b1;
          end
        end
        StRun: begin
          if (w_pixAcc) begin
            r_pixCnt    <= r_pixCnt + 1'b1;
            r_streaming <= 1'b1;
          end else if (r_streaming && data_ready) begin
            r_broken <= 1'b1;
            r_err    <= 1'b1;
          end
          if (w_anyRdy && !w_allRdy) r_err <= 1'b1;
          if (result_valid) begin
            r_resCnt <= r_resCnt + 1'b1;
            if (r_resCnt == w_resTotal - 1'b1) r_state <= StDone;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  for (genvar ic = 0; ic < InputDim; ic++) begin : g_lb
    LineBuffer #(
      .DataWidth(DataWidth), .KernelSide(KernelSide), .KernelSize(KernelSize),
      .MaxRowWidth(MaxRowWidth), .MaxColWidth(MaxColWidth)
    ) u_lb (
      .Clk      (Clk),
      .Rst      (w_subRst),
      .i_col    (r_colQ),
      .i_valid  (w_pixAcc),
      .i_data   (data_in[ic*DataWidth +: DataWidth]),
      .o_window (w_window[ic*KernelSize*DataWidth +: KernelSize*DataWidth]),
      .o_ready  (w_lbReady[ic])
    );
  end

  for (genvar oc = 0; oc < OutputDim; oc++) begin : g_cc
    ConvChannel #(
      .DataWidth(DataWidth), .KernelSize(KernelSize), .InputDim(InputDim)
    ) u_cc (
      .Clk           (Clk),
      .Rst           (w_subRst),
      .i_weightValid (w_wAcc && (r_ocCnt == OcW'(oc))),
      .i_weight      (weight_in),
      .i_windowValid (w_winValid),
      .i_window      (w_window),
      .o_result      (w_results[oc*DataWidth +: DataWidth]),
      .o_resultReady (w_ccReady[oc])
    );
  end
endmodule

// File: tb/tb_conv_top_mc.sv
// Directed-vector bench for conv_top_mc: layer sequencing, kernel routing,
// size/stream error handling and asynchronous reset recovery.

module tb_conv_top_mc;
  localparam int DW = 64;
  localparam int ID = 4;
  localparam int OD = 2;

  logic           Clk = 1'b0;
  logic           Rst_n, start, weight_valid, weight_ready, data_valid, data_ready;
  logic           result_valid, busy, done, err;
  logic [8:0]     row_in, col_in;
  logic [ID*DW-1:0] weight_in, data_in;
  logic [OD*DW-1:0] result_out;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] gotL0[$], gotL1[$], expL0[$], expL1[$];
  int   lastResCyc, doneCyc, sentCnt;
  logic busyAtDone, busyBeforeDone;

  // Layer stimulus: pixel(ic,idx) = pBase + pRamp*idx + pChan*ic, weight(k,t) = kBase[k] + kRamp[k]*t
  int kBase[OD], kRamp[OD];
  int pBase, pRamp, pChan;

  always #5 Clk = ~Clk;

  conv_top_mc dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .row_in(row_in), .col_in(col_in),
    .weight_in(weight_in), .weight_valid(weight_valid), .weight_ready(weight_ready),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .result_out(result_out), .result_valid(result_valid),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [DW-1:0] pixv(input int idx, input int ic);
    return DW'(pBase + pRamp*idx + pChan*ic);
  endfunction

  function automatic logic [DW-1:0] wv(input int k, input int t);
    return DW'(kBase[k] + kRamp[k]*t);
  endfunction

  task automatic set_layer(input int k0b, input int k0r, input int k1b, input int k1r,
                           input int pb, input int pr, input int pc);
    kBase[0] = k0b; kRamp[0] = k0r; kBase[1] = k1b; kRamp[1] = k1r;
    pBase = pb; pRamp = pr; pChan = pc;
  endtask

  task automatic build_expected(input int rows, input int cols);
    expL0.delete(); expL1.delete();
    for (int r0 = 0; r0 <= rows-3; r0++)
      for (int c0 = 0; c0 <= cols-3; c0++)
        for (int k = 0; k < OD; k++) begin
          logic [DW-1:0] s;
          s = '0;
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              for (int ic = 0; ic < ID; ic++)
                s += wv(k, ky*3+kx) * pixv((r0+ky)*cols + c0 + kx, ic);
          if (k == 0) expL0.push_back(s); else expL1.push_back(s);
        end
  endtask

  task automatic do_reset();
    Rst_n = 1'b0; start = 1'b0; weight_valid = 1'b0; data_valid = 1'b0;
    weight_in = '0; data_in = '0; row_in = '0; col_in = '0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic do_start(input int rows, input int cols);
    @(negedge Clk);
    start = 1'b1; row_in = 9'(rows); col_in = 9'(cols);
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic load_weights(input logic [31:0] gapMask, output int ok);
    int beat, cyc;
    logic gapped;
    beat = 0; cyc = 0; gapped = 1'b0;
    while (beat < OD*9 && cyc < 200) begin
      if (gapMask[beat] && !gapped) begin
        weight_valid = 1'b0;
        gapped = 1'b1;
      end else begin
        weight_valid = 1'b1;
        for (int ic = 0; ic < ID; ic++) weight_in[ic*DW +: DW] = wv(beat/9, beat%9);
        if (weight_ready) begin
          beat++;
          gapped = 1'b0;
        end
      end
      @(negedge Clk);
      cyc++;
    end
    weight_valid = 1'b0;
    ok = (beat == OD*9) ? 1 : 0;
  endtask

  task automatic stream(input int rows, input int cols, input int stopAt, input int budget);
    int cyc, npix;
    logic prevBusy;
    sentCnt = 0; cyc = 0; npix = rows*cols; prevBusy = 1'b0;
    gotL0.delete(); gotL1.delete();
    lastResCyc = -1; doneCyc = -1; busyAtDone = 1'b1; busyBeforeDone = 1'b0;
    while (cyc < budget && doneCyc < 0) begin
      if (result_valid) begin
        gotL0.push_back(result_out[0 +: DW]);
        gotL1.push_back(result_out[DW +: DW]);
        lastResCyc = cyc;
      end
      if (done) begin
        doneCyc = cyc; busyAtDone = busy; busyBeforeDone = prevBusy;
      end
      prevBusy = busy;
      if (sentCnt < npix && sentCnt < stopAt) begin
        data_valid = 1'b1;
        for (int ic = 0; ic < ID; ic++) data_in[ic*DW +: DW] = pixv(sentCnt, ic);
        if (data_ready) sentCnt++;
      end else begin
        data_valid = 1'b0;
      end
      @(negedge Clk);
      cyc++;
    end
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b1; start = 1'b0; weight_valid = 1'b0; data_valid = 1'b0;
    weight_in = '0; data_in = '0; row_in = '0; col_in = '0;
    #1 Rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, err, weight_ready, data_ready, result_valid} !== 6'b0) begin
      bad++; $display("[TB] FAIL reset_flags: got %b want 000000", {busy, done, err, weight_ready, data_ready, result_valid});
    end
    total++;
    if (result_out !== '0) begin
      bad++; $display("[TB] FAIL reset_result: got %0h want 0", result_out);
    end
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    total++;
    if ({busy, done, err, weight_ready, data_ready, result_valid} !== 6'b0) begin
      bad++; $display("[TB] FAIL idle_flags: got %b want 000000", {busy, done, err, weight_ready, data_ready, result_valid});
    end
  endtask

  task automatic test_nominal();
    int ok;
    set_layer(1, 0, 1, 0, 1, 0, 0);
    do_start(5, 5);
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL nom_busy_start: got %b want 1", busy); end
    load_weights(32'h0000_4208, ok);
    total++;
    if (ok !== 1) begin bad++; $display("[TB] FAIL nom_load: got %0d want 1", ok); end
    total++;
    if ({weight_ready, data_ready} !== 2'b01) begin
      bad++; $display("[TB] FAIL nom_run_entry: got %b want 01", {weight_ready, data_ready});
    end
    stream(5, 5, 25, 200);
    total++;
    if (gotL0.size() !== 9) begin bad++; $display("[TB] FAIL nom_count: got %0d want 9", gotL0.size()); end
    for (int i = 0; i < gotL0.size(); i++) begin
      total++;
      if (gotL0[i] !== 64'd36 || gotL1[i] !== 64'd36) begin
        bad++; $display("[TB] FAIL nom_lane[%0d]: got %0d/%0d want 36/36", i, gotL0[i], gotL1[i]);
      end
    end
    total++;
    if (doneCyc !== lastResCyc + 1) begin
      bad++; $display("[TB] FAIL nom_done_timing: got cycle %0d want %0d", doneCyc, lastResCyc + 1);
    end
    total++;
    if ({busyBeforeDone, busyAtDone, err} !== 3'b100) begin
      bad++; $display("[TB] FAIL nom_busy_done: got %b want 100", {busyBeforeDone, busyAtDone, err});
    end
    total++;
    if ({done, busy} !== 2'b00) begin bad++; $display("[TB] FAIL nom_done_pulse: got %b want 00", {done, busy}); end
  endtask

  task automatic test_routing();
    int ok;
    set_layer(1, 0, 2, 0, 1, 0, 0);
    do_start(5, 5);
    start = 1'b1; row_in = 9'd2; col_in = 9'd7;
    @(negedge Clk);
    start = 1'b0;
    load_weights(32'h0, ok);
    stream(5, 5, 25, 200);
    total++;
    if (gotL0.size() !== 9 || err !== 1'b0) begin
      bad++; $display("[TB] FAIL route_count_err: got %0d/%b want 9/0", gotL0.size(), err);
    end
    for (int i = 0; i < gotL0.size(); i++) begin
      total++;
      if (gotL0[i] !== 64'd36 || gotL1[i] !== 64'd72) begin
        bad++; $display("[TB] FAIL route_lane[%0d]: got %0d/%0d want 36/72", i, gotL0[i], gotL1[i]);
      end
    end
  endtask

  task automatic test_bad_size();
    int ok;
    do_start(2, 5);
    total++;
    if ({err, busy, weight_ready} !== 3'b100) begin
      bad++; $display("[TB] FAIL bad_row: got %b want 100", {err, busy, weight_ready});
    end
    repeat (3) @(negedge Clk);
    total++;
    if ({err, busy, weight_ready} !== 3'b100) begin
      bad++; $display("[TB] FAIL bad_row_hold: got %b want 100", {err, busy, weight_ready});
    end
    do_start(5, 417);
    total++;
    if ({err, busy} !== 2'b10) begin bad++; $display("[TB] FAIL bad_col417: got %b want 10", {err, busy}); end
    set_layer(1, 1, 2, 0, 1, 1, 1);
    do_start(3, 3);
    total++;
    if ({err, busy} !== 2'b01) begin bad++; $display("[TB] FAIL bad_clear: got %b want 01", {err, busy}); end
    load_weights(32'h0, ok);
    stream(3, 3, 9, 100);
    build_expected(3, 3);
    total++;
    if (gotL0.size() !== 1 || doneCyc < 0) begin
      bad++; $display("[TB] FAIL min_layer: got %0d results done_cyc %0d want 1 and done", gotL0.size(), doneCyc);
    end else begin
      total++;
      if (gotL0[0] !== expL0[0] || gotL1[0] !== expL1[0]) begin
        bad++; $display("[TB] FAIL min_lane: got %0d/%0d want %0d/%0d", gotL0[0], gotL1[0], expL0[0], expL1[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ok;
    int rows[2];
    int cols[2];
    rows[0] = 5; cols[0] = 5; rows[1] = 4; cols[1] = 6;
    for (int l = 0; l < 2; l++) begin
      if (l == 0) set_layer(1, 0, 1, 1, 1, 1, 1);
      else        set_layer(2, 0, 0, 3, 3, 2, 0);
      build_expected(rows[l], cols[l]);
      do_start(rows[l], cols[l]);
      load_weights(32'h0000_0400, ok);
      stream(rows[l], cols[l], rows[l]*cols[l], 200);
      total++;
      if (gotL0.size() !== expL0.size() || doneCyc < 0) begin
        bad++; $display("[TB] FAIL b2b_count[%0d]: got %0d want %0d", l, gotL0.size(), expL0.size());
      end
      for (int i = 0; i < expL0.size() && i < gotL0.size(); i++) begin
        total++;
        if (gotL0[i] !== expL0[i] || gotL1[i] !== expL1[i]) begin
          bad++; $display("[TB] FAIL b2b_lane[%0d][%0d]: got %0d/%0d want %0d/%0d",
                          l, i, gotL0[i], gotL1[i], expL0[i], expL1[i]);
        end
      end
    end
  endtask

  task automatic test_stream_break();
    int ok;
    set_layer(1, 0, 1, 0, 1, 0, 0);
    do_start(5, 5);
    load_weights(32'h0, ok);
    stream(5, 5, 10, 20);
    total++;
    if ({err, data_ready, busy} !== 3'b101) begin
      bad++; $display("[TB] FAIL break_flags: got %b want 101", {err, data_ready, busy});
    end
    total++;
    if (dut.r_pixCnt !== 18'd10) begin bad++; $display("[TB] FAIL break_pixcnt: got %0d want 10", dut.r_pixCnt); end
    total++;
    if (gotL0.size() !== 0 || sentCnt !== 10) begin
      bad++; $display("[TB] FAIL break_results: got %0d results %0d sent want 0/10", gotL0.size(), sentCnt);
    end
    do_reset();
  endtask

  task automatic test_async_reset();
    int ok, sent, cyc;
    set_layer(1, 0, 1, 0, 1, 0, 0);
    do_start(5, 5);
    load_weights(32'h0, ok);
    sent = 0; cyc = 0;
    while (sent < 12 && cyc < 100) begin
      data_valid = 1'b1;
      for (int ic = 0; ic < ID; ic++) data_in[ic*DW +: DW] = pixv(sent, ic);
      if (data_ready) sent++;
      @(negedge Clk);
      cyc++;
    end
    total++;
    if (sent !== 12 || busy !== 1'b1) begin bad++; $display("[TB] FAIL arst_pre: got %0d/%b want 12/1", sent, busy); end
    #2 Rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, err, weight_ready, data_ready, result_valid} !== 6'b0 || result_out !== '0) begin
      bad++; $display("[TB] FAIL arst_outputs: got %b/%0h want 000000/0",
                      {busy, done, err, weight_ready, data_ready, result_valid}, result_out);
    end
    data_valid = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    do_start(5, 5);
    load_weights(32'h0, ok);
    stream(5, 5, 25, 200);
    total++;
    if (gotL0.size() !== 9 || doneCyc < 0) begin
      bad++; $display("[TB] FAIL arst_count: got %0d want 9", gotL0.size());
    end
    for (int i = 0; i < gotL0.size(); i++) begin
      total++;
      if (gotL0[i] !== 64'd36 || gotL1[i] !== 64'd36) begin
        bad++; $display("[TB] FAIL arst_lane[%0d]: got %0d/%0d want 36/36", i, gotL0[i], gotL1[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_routing();
    test_bad_size();
    test_back_to_back();
    test_stream_break();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
